// File: rtl/alu32_serial_add_ctrl.sv
// Multi-cycle 32-bit add/subtract built on one 5-bit carry-lookahead slice, LSB chunk first.
// Optional macro ALU32_SERADD_EARLY_EXIT_EN finishes early once the upper operand bits and carry are 0.
module alu32_serial_add_ctrl #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SLICE_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             zero,
  output logic             busy
);

  localparam int unsigned N_SLICE = (WIDTH + SLICE_W - 1) / SLICE_W;
  localparam logic [2:0]  LastK   = 3'(N_SLICE - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state;
  logic [WIDTH-1:0]  op_a, op_b;
  logic              carry;
  logic [2:0]        k;

  logic [5:0]        shamt;
  logic [4:0]        sa, sb, g, p, sum;
  logic [5:0]        c;
  logic [WIDTH-1:0]  result_nxt;
  logic              c31;

  assign start_ready = (state == StIdle) && !rst;
  assign busy        = (state != StIdle);
  assign res_valid   = (state == StDone);

  // The top chunk shifts down to two live bits, so zero padding comes for free.
  always_comb begin
    shamt = 6'(k * SLICE_W);
    sa    = 5'(op_a >> shamt);
    sb    = 5'(op_b >> shamt);
    g     = sa & sb;
    p     = sa ^ sb;
    c[0]  = carry;
    c[1]  = g[0] | (p[0] & c[0]);
    c[2]  = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3]  = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    c[4]  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
          | (p[3] & p[2] & p[1] & p[0] & c[0]);
    c[5]  = g[4] | (p[4] & g[3]) | (p[4] & p[3] & g[2]) | (p[4] & p[3] & p[2] & g[1])
          | (p[4] & p[3] & p[2] & p[1] & g[0]) | (p[4] & p[3] & p[2] & p[1] & p[0] & c[0]);
    sum   = p ^ c[4:0];
    // Each chunk is written once into a zeroed result, so OR-ing in place is exact.
    result_nxt = result | (WIDTH'(sum) << shamt);
    c31        = op_a[WIDTH-1] ^ op_b[WIDTH-1] ^ result_nxt[WIDTH-1];
  end

`ifdef ALU32_SERADD_EARLY_EXIT_EN
  logic early_exit;
  always_comb begin
    early_exit = ((op_a >> (shamt + 6'(SLICE_W))) == '0) &&
                 ((op_b >> (shamt + 6'(SLICE_W))) == '0) && !c[5];
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= StIdle;
      op_a     <= '0;
      op_b     <= '0;
      carry    <= 1'b0;
      k        <= '0;
      result   <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else begin
      case (state)
        StIdle: begin
          if (start_valid) begin
            op_a   <= a;
            op_b   <= sub ? ~b : b;
            carry  <= sub ? 1'b1 : cin;
            k      <= '0;
            result <= '0;
            state  <= StRun;
          end
        end
        StRun: begin
          result <= result_nxt;
          carry  <= c[5];
          if (k == LastK) begin
            cout     <= sum[2];
            overflow <= c31 ^ sum[2];
            zero     <= (result_nxt == '0);
            state    <= StDone;
`ifdef ALU32_SERADD_EARLY_EXIT_EN
          end else if (early_exit) begin
            cout     <= 1'b0;
            overflow <= 1'b0;
            zero     <= (result_nxt == '0);
            state    <= StDone;
`endif
          end else begin
            k <= k + 3'd1;
          end
        end
        StDone: begin
          if (res_ready) state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
